// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// Shared definitions for the nibble-serial adder: FSM encoding, nibble width
// and the WIDTH legality check used at elaboration.
package nibble_serial_adder_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int NIBBLE_W = 4;

    function automatic bit width_ok(input int width);
        return (width >= NIBBLE_W) && ((width % NIBBLE_W) == 0);
    endfunction

endpackage

// File: rtl/nibble_serial_adder_ctrl_nibble_adder.sv
// Combinational 4-bit ripple-carry adder built from four full adders.
// c3 is the carry into bit 3, needed by the parent for signed overflow.
module nibble_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout,
    output logic       c3
);

    logic c1;
    logic c2;

    assign sum[0] = a[0] ^ b[0] ^ cin;
    assign c1     = (a[0] & b[0]) | (cin & (a[0] ^ b[0]));
    assign sum[1] = a[1] ^ b[1] ^ c1;
    assign c2     = (a[1] & b[1]) | (c1 & (a[1] ^ b[1]));
    assign sum[2] = a[2] ^ b[2] ^ c2;
    assign c3     = (a[2] & b[2]) | (c2 & (a[2] ^ b[2]));
    assign sum[3] = a[3] ^ b[3] ^ c3;
    assign cout   = (a[3] & b[3]) | (c3 & (a[3] ^ b[3]));

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Multi-word add engine: one shared 4-bit adder is stepped across the
// operands LSB nibble first, with the carry held in a register between passes.
//
//   state   | meaning
//   IDLE    | waiting for Start; result outputs hold the last completed add
//   RUN     | one nibble added per clock, Busy=1
//   DONE    | single cycle, Done=1; a Start here is accepted back-to-back
module nibble_serial_adder_ctrl
    import nibble_serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CarryIn,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Sum,
    output logic             CarryOut,
    output logic             Overflow
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    if (!width_ok(WIDTH)) begin : g_bad_width
        $error("nibble_serial_adder_ctrl: WIDTH must be a multiple of 4 and at least 4");
    end

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   op_a_q, op_a_d;
    logic [WIDTH-1:0]   op_b_q, op_b_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic [IDX_W-1:0]   nib_idx_q, nib_idx_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [NIBBLE_W-1:0] nib_a;
    logic [NIBBLE_W-1:0] nib_b;
    logic [NIBBLE_W-1:0] add_sum;
    logic                add_cout;
    logic                add_c3;

    always_comb begin
        nib_a = '0;
        nib_b = '0;
        for (int n = 0; n < NIBBLES; n++) begin
            if (nib_idx_q == IDX_W'(n)) begin
                nib_a = op_a_q[n*NIBBLE_W +: NIBBLE_W];
                nib_b = op_b_q[n*NIBBLE_W +: NIBBLE_W];
            end
        end
    end

    nibble_adder u_nibble_adder (
        .a    (nib_a),
        .b    (nib_b),
        .cin  (carry_q),
        .sum  (add_sum),
        .cout (add_cout),
        .c3   (add_c3)
    );

    always_comb begin
        state_d   = state_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        sum_d     = sum_q;
        nib_idx_d = nib_idx_q;
        carry_d   = carry_q;
        cout_d    = cout_q;
        ovf_d     = ovf_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (Start) begin
                    op_a_d    = A;
                    op_b_d    = B;
                    carry_d   = CarryIn;
                    sum_d     = '0;
                    nib_idx_d = '0;
                    state_d   = ST_RUN;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_RUN: begin
                for (int n = 0; n < NIBBLES; n++) begin
                    if (nib_idx_q == IDX_W'(n)) begin
                        sum_d[n*NIBBLE_W +: NIBBLE_W] = add_sum;
                    end
                end
                carry_d   = add_cout;
                nib_idx_d = nib_idx_q + 1'b1;
                if (nib_idx_q == LAST_IDX) begin
                    cout_d  = add_cout;
                    ovf_d   = add_c3 ^ add_cout;
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Status flags are registered from the next state so they align with it.
        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            op_a_q    <= '0;
            op_b_q    <= '0;
            sum_q     <= '0;
            nib_idx_q <= '0;
            carry_q   <= 1'b0;
            cout_q    <= 1'b0;
            ovf_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            sum_q     <= sum_d;
            nib_idx_q <= nib_idx_d;
            carry_q   <= carry_d;
            cout_q    <= cout_d;
            ovf_q     <= ovf_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign Busy     = busy_q;
    assign Done     = done_q;
    assign Sum      = sum_q;
    assign CarryOut = cout_q;
    assign Overflow = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Self-checking bench: directed and random 16-bit adds plus an exhaustive
// 4-bit sweep, all compared against a plain-arithmetic reference model.
module tb_nibble_serial_adder_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        start16, cin16;
    logic [15:0] a16, b16;
    logic        busy16, done16, cout16, ovf16;
    logic [15:0] sum16;

    logic        start4, cin4;
    logic [3:0]  a4, b4;
    logic        busy4, done4, cout4, ovf4;
    logic [3:0]  sum4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    nibble_serial_adder_ctrl #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .Start(start16), .A(a16), .B(b16), .CarryIn(cin16),
        .Busy(busy16), .Done(done16), .Sum(sum16), .CarryOut(cout16), .Overflow(ovf16)
    );

    nibble_serial_adder_ctrl #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .Start(start4), .A(a4), .B(b4), .CarryIn(cin4),
        .Busy(busy4), .Done(done4), .Sum(sum4), .CarryOut(cout4), .Overflow(ovf4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: unsigned sum modulo 2^w, carry out, and signed-range overflow.
    function automatic void model(input int w, input logic [31:0] a, input logic [31:0] b,
                                  input logic cin, output logic [31:0] s,
                                  output logic co, output logic ov);
        longint ua, ub, full, half, sa, sb, ss;
        ua   = longint'(a);
        ub   = longint'(b);
        full = ua + ub + longint'(cin);
        half = longint'(1) << (w - 1);
        s    = 32'(full & ((longint'(1) << w) - 1));
        co   = ((full >> w) & 1) != 0;
        sa   = (ua >= half) ? ua - 2 * half : ua;
        sb   = (ub >= half) ? ub - 2 * half : ub;
        ss   = sa + sb + longint'(cin);
        ov   = (ss >= half) || (ss < -half);
    endfunction

    // Called at a negedge; returns at a negedge with the block idle.
    task automatic run16(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic [15:0] es, input logic eco,
                         input logic eov);
        start16 = 1'b1; a16 = a; b16 = b; cin16 = cin;
        @(negedge clk);
        start16 = 1'b0;
        a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom);
        for (int k = 0; k < 4; k++) begin
            chk({tag, " busy"}, {30'd0, busy16, done16}, 32'b10);
            @(negedge clk);
        end
        chk({tag, " done"}, {30'd0, busy16, done16}, 32'b01);
        chk({tag, " sum"}, {16'd0, sum16}, {16'd0, es});
        chk({tag, " cout/ovf"}, {30'd0, cout16, ovf16}, {30'd0, eco, eov});
        @(negedge clk);
        chk({tag, " idle"}, {30'd0, busy16, done16}, 32'b00);
        chk({tag, " hold"}, {15'd0, cout16, sum16}, {15'd0, eco, es});
    endtask

    initial begin
        logic [31:0] ms;
        logic        mco, mov;
        logic [15:0] ra, rb;
        logic        rc;
        int          dones, done_at;

        rst_n = 1'b0;
        start16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0;
        start4  = 1'b0; a4  = '0; b4  = '0; cin4  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset16", {busy16, done16, cout16, ovf16, sum16}, 32'd0);
        chk("reset4", {busy4, done4, cout4, ovf4, sum4}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run16("ffff+1", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        run16("7fff+1", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        run16("1234+4321+c", 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0);

        // Back-to-back with Start held high.
        start16 = 1'b1; a16 = 16'h00FF; b16 = 16'h0F01; cin16 = 1'b0;
        @(negedge clk);
        for (int op = 0; op < 3; op++) begin
            for (int k = 0; k < 4; k++) begin
                chk("b2b busy", {30'd0, busy16, done16}, 32'b10);
                @(negedge clk);
            end
            chk("b2b done", {30'd0, busy16, done16}, 32'b01);
            chk("b2b sum", {15'd0, cout16, sum16}, 32'h1000);
            if (op == 2) start16 = 1'b0;
            @(negedge clk);
        end
        chk("b2b idle", {30'd0, busy16, done16}, 32'b00);

        // Start during RUN must be ignored.
        start16 = 1'b1; a16 = 16'h1111; b16 = 16'h2222; cin16 = 1'b0;
        @(negedge clk);
        start16 = 1'b0;
        @(negedge clk);
        start16 = 1'b1; a16 = 16'hAAAA; b16 = 16'h5555; cin16 = 1'b1;
        dones = 0; done_at = -1;
        for (int k = 1; k < 10; k++) begin
            if (done16) begin
                dones++;
                done_at = k;
                chk("ignore sum", {16'd0, sum16}, 32'h3333);
            end
            @(negedge clk);
            start16 = 1'b0;
        end
        chk("ignore done count", dones, 1);
        chk("ignore done time", done_at, 4);

        // Reset mid-operation; previous CarryOut=1 must be cleared too.
        run16("pre-reset", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        start16 = 1'b1; a16 = 16'h1234; b16 = 16'h1111; cin16 = 1'b0;
        @(negedge clk);
        start16 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort state", {busy16, done16, cout16, ovf16, sum16}, 32'd0);
        dones = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (done16 || busy16) dones++;
        end
        chk("abort no done", dones, 0);
        run16("after reset", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);

        for (int i = 0; i < 25; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom);
            if (i == 0) begin ra = 16'h8000; rb = 16'h8000; rc = 1'b0; end
            if (i == 1) begin ra = 16'h7FFF; rb = 16'h0000; rc = 1'b1; end
            model(16, {16'd0, ra}, {16'd0, rb}, rc, ms, mco, mov);
            run16("random", ra, rb, rc, ms[15:0], mco, mov);
        end

        // Exhaustive 4-bit sweep, each Start issued in the previous DONE cycle.
        for (int i = 0; i < 512; i++) begin
            logic [8:0] v;
            v = 9'(i);
            start4 = 1'b1; a4 = v[3:0]; b4 = v[7:4]; cin4 = v[8];
            @(negedge clk);
            start4 = 1'b0; a4 = ~a4; b4 = ~b4;
            chk("w4 busy", {30'd0, busy4, done4}, 32'b10);
            @(negedge clk);
            model(4, {28'd0, v[3:0]}, {28'd0, v[7:4]}, v[8], ms, mco, mov);
            chk("w4 done", {30'd0, busy4, done4}, 32'b01);
            chk("w4 result", {26'd0, ovf4, cout4, sum4}, {26'd0, mov, mco, ms[3:0]});
        end
        @(negedge clk);
        chk("w4 idle", {30'd0, busy4, done4}, 32'b00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
